cdc_strobe_source: RTL

CDC_STROBE_SOURCE -- requirements
Module: cdc_strobe_source

---
 rtl/cdc_hndshk_pkg.sv | 23 ++
 rtl/cdc_down_counter.sv | 38 +++
 rtl/cdc_strobe_source.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cdc_hndshk_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// cdc_hndshk_pkg : state type and default run constants for the
//                  strobe source.                           Rev 1.0
// ---------------------------------------------------------------------
package cdc_hndshk_pkg;

   localparam int unsigned DEF_PULSE_LIMIT = 5;
   localparam int unsigned DEF_GAP_CYCLES  = 2;
   localparam int unsigned DEF_ACK_TIMEOUT = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_ACK     = 3'd3,
      ST_RELEASE = 3'd4,
      ST_GAP     = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

endpackage
`default_nettype wire

// File: rtl/cdc_down_counter.sv
`default_nettype none
// ---------------------------------------------------------------------
// cdc_down_counter : 8-bit loadable down counter with zero flag,
//                    saturating at zero.                    Rev 1.0
// ---------------------------------------------------------------------
module cdc_down_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_value,
   input  logic       dec,
   output logic       zero
);

   logic [7:0] count_d;
   logic [7:0] count_q;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (dec && (count_q != 8'd0)) begin
         count_d = count_q - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == 8'd0);

endmodule
`default_nettype wire

// File: rtl/cdc_strobe_source.sv
`default_nettype none
// ---------------------------------------------------------------------
// cdc_strobe_source : issues a run of handshaked strobes into a CDC
//                     source. Optional ack timeout: CDC_STROBE_SOURCE_TIMEOUT_EN.
//                                                          Rev 1.0
// ---------------------------------------------------------------------
module cdc_strobe_source
   import cdc_hndshk_pkg::*;
#(
   parameter int unsigned PULSE_LIMIT = DEF_PULSE_LIMIT,
   parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic        source_clk,
   input  logic        source_reset_n,
   input  logic        start,
   input  logic        source_stall,
   output logic        source_strobe,
   output logic        busy,
   output logic        done,
   output logic [15:0] sent_count,
   output logic        timeout_err
);

   localparam logic [15:0] LIMIT    = 16'(PULSE_LIMIT);
   localparam logic [7:0]  GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

   if ((PULSE_LIMIT > 65535) || (GAP_CYCLES > 255) ||
       (ACK_TIMEOUT < 1) || (ACK_TIMEOUT > 255)) begin : g_bad_params
      $error("cdc_strobe_source: parameter out of range");
   end

   state_t      state_d, state_q;
   state_t      after_gap;
   logic        strobe_d, strobe_q;
   logic        busy_d, busy_q;
   logic        done_d, done_q;
   logic [15:0] sent_count_d, sent_count_q;
   logic        start_accept;
   logic        gap_zero;
   logic        ack_expired;

   assign start_accept = (state_q == ST_IDLE) && start;
   assign after_gap    = (sent_count_q < LIMIT) ? ST_ISSUE : ST_DONE;

   // Loaded as stall drops in RELEASE so the zero flag marks the last GAP cycle.
   cdc_down_counter u_gap_counter (
      .clk        (source_clk),
      .rst_n      (source_reset_n),
      .load       ((state_q == ST_RELEASE) && !source_stall),
      .load_value (GAP_LOAD),
      .dec        (state_q == ST_GAP),
      .zero       (gap_zero)
   );

`ifdef CDC_STROBE_SOURCE_TIMEOUT_EN
   localparam logic [7:0] ACK_LOAD = 8'(ACK_TIMEOUT - 1);

   logic ack_zero;
   logic timeout_err_d, timeout_err_q;

   cdc_down_counter u_ack_counter (
      .clk        (source_clk),
      .rst_n      (source_reset_n),
      .load       (state_q == ST_STROBE),
      .load_value (ACK_LOAD),
      .dec        (state_q == ST_ACK),
      .zero       (ack_zero)
   );

   assign ack_expired = (state_q == ST_ACK) && !source_stall && ack_zero;

   always_comb begin
      timeout_err_d = timeout_err_q;
      if (start_accept) begin
         timeout_err_d = 1'b0;
      end else if (ack_expired) begin
         timeout_err_d = 1'b1;
      end
   end

   always_ff @(posedge source_clk) begin
      if (!source_reset_n) begin
         timeout_err_q <= 1'b0;
      end else begin
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign ack_expired = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      sent_count_d = sent_count_q;
      case (state_q)
         ST_IDLE: begin
            if (start_accept) begin
               sent_count_d = 16'd0;
               state_d      = (LIMIT == 16'd0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!source_stall) state_d = ST_STROBE;
         end
         ST_STROBE: begin
            sent_count_d = sent_count_q + 16'd1;
            state_d      = ST_ACK;
         end
         ST_ACK: begin
            if (source_stall)     state_d = ST_RELEASE;
            else if (ack_expired) state_d = ST_DONE;
         end
         ST_RELEASE: begin
            if (!source_stall) state_d = (GAP_CYCLES == 0) ? after_gap : ST_GAP;
         end
         ST_GAP: begin
            if (gap_zero) state_d = after_gap;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Outputs are registered from the next state so they align with it.
      strobe_d = (state_d == ST_STROBE);
      busy_d   = (state_d != ST_IDLE);
      done_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge source_clk) begin
      if (!source_reset_n) begin
         state_q      <= ST_IDLE;
         strobe_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         sent_count_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         strobe_q     <= strobe_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         sent_count_q <= sent_count_d;
      end
   end

   assign source_strobe = strobe_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign sent_count    = sent_count_q;

endmodule
`default_nettype wire
